// File: rtl/hazard_ctrl_unit.sv
// Stall/flush/forward sequencer for the rv32i 5-stage pipeline, with a memory-wait watchdog FSM.
// Optional FORWARDING_EN: forward from shadow M/W destinations; otherwise every RAW hazard stalls.
module hazard_ctrl_unit #(
  parameter int ADW      = 5,
  parameter int MAX_WAIT = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [ADW-1:0] Rs1D,
  input  logic [ADW-1:0] Rs2D,
  input  logic [ADW-1:0] Rs1E,
  input  logic [ADW-1:0] Rs2E,
  input  logic [ADW-1:0] RdE,
  input  logic           regwriteE,
  input  logic           resultsrcE,
  input  logic           pcsrcE,
  input  logic           mem_req,
  input  logic           mem_ready,
  output logic           stallF,
  output logic           stallD,
  output logic           stallE,
  output logic           stallM,
  output logic           flushD,
  output logic           flushE,
  output logic [1:0]     forwardAE,
  output logic [1:0]     forwardBE,
  output logic           mem_err
);
  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] WAIT_LIM = CW'(MAX_WAIT);

  typedef enum logic [1:0] {S_RUN, S_WAIT, S_ERROR} state_t;

  state_t         state, state_nxt;
  logic [CW-1:0]  wait_cnt, cnt_nxt, cnt_inc;
  logic           err_nxt;
  logic           mem_stall;
  logic           hz_stall;
  logic [ADW-1:0] RdM, RdW;
  logic           regwriteM, regwriteW;

  function automatic logic hit(input logic we, input logic [ADW-1:0] rd, input logic [ADW-1:0] rs);
    return we && (rd != '0) && (rd == rs);
  endfunction

  assign mem_stall = (mem_req && !mem_ready) || (state == S_ERROR);
  assign cnt_inc   = (wait_cnt == WAIT_LIM) ? wait_cnt : wait_cnt + CW'(1);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = wait_cnt;
    err_nxt   = mem_err;
    case (state)
      S_RUN: begin
        if (mem_req && !mem_ready) begin
          state_nxt = S_WAIT;
          cnt_nxt   = CW'(1);
        end
      end
      S_WAIT: begin
        if (mem_ready) begin
          state_nxt = S_RUN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_inc;
          if (cnt_inc == WAIT_LIM) begin
            state_nxt = S_ERROR;
            err_nxt   = 1'b1;
          end
        end
      end
      S_ERROR: err_nxt = 1'b1;
      default: state_nxt = S_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_RUN;
      wait_cnt  <= '0;
      mem_err   <= 1'b0;
      RdM       <= '0;
      RdW       <= '0;
      regwriteM <= 1'b0;
      regwriteW <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= cnt_nxt;
      mem_err  <= err_nxt;
      // Shadow copy advances only when the real M/W registers do.
      if (!mem_stall) begin
        RdM       <= RdE;
        regwriteM <= regwriteE && !flushE;
        RdW       <= RdM;
        regwriteW <= regwriteM;
      end
    end
  end

`ifdef FORWARDING_EN
  assign hz_stall = resultsrcE && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));

  always_comb begin
    forwardAE = 2'b00;
    forwardBE = 2'b00;
    if (hit(regwriteM, RdM, Rs1E))      forwardAE = 2'b10;
    else if (hit(regwriteW, RdW, Rs1E)) forwardAE = 2'b01;
    if (hit(regwriteM, RdM, Rs2E))      forwardBE = 2'b10;
    else if (hit(regwriteW, RdW, Rs2E)) forwardBE = 2'b01;
  end
`else
  // Without bypass paths any in-flight writer of a decode source must drain first.
  assign hz_stall = hit(regwriteE, RdE, Rs1D) || hit(regwriteE, RdE, Rs2D) ||
                    hit(regwriteM, RdM, Rs1D) || hit(regwriteM, RdM, Rs2D) ||
                    hit(regwriteW, RdW, Rs1D) || hit(regwriteW, RdW, Rs2D);
  assign forwardAE = 2'b00;
  assign forwardBE = 2'b00;

  logic unused_fwd_inputs;
  assign unused_fwd_inputs = ^{Rs1E, Rs2E, resultsrcE};
`endif

  always_comb begin
    stallF = 1'b0;
    stallD = 1'b0;
    stallE = 1'b0;
    stallM = 1'b0;
    flushD = 1'b0;
    flushE = 1'b0;
    if (!rst_n) begin
      stallF = 1'b0;
    end else if (mem_stall) begin
      // Branch is deferred: E is frozen, so pcsrcE re-presents on release.
      stallF = 1'b1;
      stallD = 1'b1;
      stallE = 1'b1;
      stallM = 1'b1;
    end else if (pcsrcE) begin
      flushD = 1'b1;
      flushE = 1'b1;
    end else if (hz_stall) begin
      stallF = 1'b1;
      stallD = 1'b1;
      flushE = 1'b1;
    end
  end

endmodule
